// File: rtl/instr_sequencer.sv
// Fetch/sequence engine: walks pc over instruction memory, latches opcode/operand, executes until halt.
// Optional macro INSTR_SEQ_WRAP_HALT_EN: halt with wrap_err instead of wrapping pc past the last address.
module instr_sequencer #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned OPC_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_valid,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic [OPC_W-1:0]         opcode,
    output logic [INSTR_W-OPC_W-1:0] operand,
    output logic                     exec_en,
    input  logic                     stall,
    input  logic                     halt,
    output logic [ADDR_W-1:0]        pc,
    output logic                     running,
    output logic                     halted,
    output logic                     wrap_err
);

    localparam int unsigned OPR_W = INSTR_W - OPC_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [OPC_W-1:0]   r_opcode;
    logic [OPC_W-1:0]   w_opcode_nxt;
    logic [OPR_W-1:0]   r_operand;
    logic [OPR_W-1:0]   w_operand_nxt;
    logic               r_wrap_err;
    logic               w_wrap_err_nxt;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_wrap_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_opcode   <= w_opcode_nxt;
            r_operand  <= w_operand_nxt;
            r_wrap_err <= w_wrap_err_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_opcode_nxt   = r_opcode;
        w_operand_nxt  = r_operand;
        w_wrap_err_nxt = r_wrap_err;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_pc_nxt       = '0;
                    w_wrap_err_nxt = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    w_opcode_nxt  = imem_rdata[INSTR_W-1 -: OPC_W];
                    w_operand_nxt = imem_rdata[OPR_W-1:0];
                    w_state_nxt   = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                // Stall takes priority; halt is only meaningful on the completing cycle
                if (!stall) begin
                    if (halt) begin
                        w_state_nxt = S_HALTED;
`ifdef INSTR_SEQ_WRAP_HALT_EN
                    end else if (r_pc == {ADDR_W{1'b1}}) begin
                        w_state_nxt    = S_HALTED;
                        w_wrap_err_nxt = 1'b1;
`endif
                    end else begin
                        w_pc_nxt    = r_pc + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are either registers or pure state decodes
    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign opcode    = r_opcode;
    assign operand   = r_operand;
    assign exec_en   = (r_state == S_EXECUTE);
    assign running   = (r_state == S_FETCH) || (r_state == S_EXECUTE);
    assign halted    = (r_state == S_HALTED);
    assign wrap_err  = r_wrap_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected executions, a monitor pops on each new EXECUTE.
module tb_instr_sequencer;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic                     imem_req;
    logic [ADDR_W-1:0]        imem_addr;
    logic                     imem_valid = 1'b0;
    logic [INSTR_W-1:0]       imem_rdata = '0;
    logic [OPC_W-1:0]         opcode;
    logic [INSTR_W-OPC_W-1:0] operand;
    logic                     exec_en;
    logic                     stall = 1'b0;
    logic                     halt = 1'b0;
    logic [ADDR_W-1:0]        pc;
    logic                     running;
    logic                     halted;
    logic                     wrap_err;

    instr_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OPC_W(OPC_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .opcode(opcode), .operand(operand), .exec_en(exec_en),
        .stall(stall), .halt(halt), .pc(pc),
        .running(running), .halted(halted), .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] opc;
        logic [3:0] opr;
        logic [3:0] pc;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] mem [16];
    int         wait_addr = -1;
    int         wait_left = 0;
    int         stall_left = 0;
    bit         halt_noise = 1'b0;
    int         req1_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] o, input logic [3:0] r, input logic [3:0] p);
        exp_t e;
        e.opc = o;
        e.opr = r;
        e.pc  = p;
        sb_q.push_back(e);
    endtask

    // Memory, stall and halt models; inputs change on the falling edge
    always @(negedge clk) begin
        if (imem_req) begin
            if (imem_addr == 4'd1) req1_cnt++;
            if (wait_left > 0 && int'(imem_addr) == wait_addr) begin
                imem_valid = 1'b0;
                wait_left--;
            end else begin
                imem_valid = 1'b1;
                imem_rdata = mem[imem_addr];
            end
        end else begin
            imem_valid = 1'b0;
        end
        if (exec_en && stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end else begin
            stall = 1'b0;
        end
        halt = exec_en ? (opcode == 4'hF) : halt_noise;
    end

    // Monitor: new EXECUTE pops the scoreboard; otherwise opcode/operand/pc must hold
    exp_t cur = '0;
    bit   prev_exec = 1'b0;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            prev_exec = 1'b0;
            cur       = '0;
        end else begin
            if (exec_en && !prev_exec) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_exec: got opcode %0h pc %0h with empty scoreboard", opcode, pc);
                end else begin
                    cur = sb_q.pop_front();
                    chk("exec_opcode", 32'(opcode), 32'(cur.opc));
                    chk("exec_operand", 32'(operand), 32'(cur.opr));
                    chk("exec_pc", 32'(pc), 32'(cur.pc));
                end
            end else if (exec_en) begin
                chk("exec_stable", 32'({opcode, operand, pc}), 32'({cur.opc, cur.opr, cur.pc}));
            end else begin
                chk("opcode_hold", 32'(opcode), 32'(cur.opc));
            end
            prev_exec = exec_en;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_until_halt(input int maxc, input bit hold_start, output int cycles, output int exec_cnt);
        cycles   = 0;
        exec_cnt = 0;
        if (hold_start) start = 1'b1;
        while (cycles < maxc) begin
            @(posedge clk);
            #1;
            cycles++;
            if (exec_en) exec_cnt++;
            if (halted) break;
        end
        start = 1'b0;
        if (!halted) begin
            checks++;
            failures++;
            $display("FAIL halt_timeout: no halt after %0d cycles", cycles);
        end
    endtask

    task automatic load_straight();
        mem[0] = 8'h1A;
        mem[1] = 8'h35;
        mem[2] = 8'h4F;
        mem[3] = 8'hF0;
    endtask

    initial begin
        int cyc;
        int ex;
        foreach (mem[i]) mem[i] = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_exec_en", 32'(exec_en), 32'd0);
        chk("rst_pc_addr", 32'({pc, imem_addr}), 32'd0);
        chk("rst_opc_opr", 32'({opcode, operand}), 32'd0);
        chk("rst_status", 32'({running, halted, wrap_err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Straight-line run, zero wait
        load_straight();
        push(4'h1, 4'hA, 4'd0);
        push(4'h3, 4'h5, 4'd1);
        push(4'h4, 4'hF, 4'd2);
        push(4'hF, 4'h0, 4'd3);
        do_start();
        chk("start_to_req", 32'(imem_req), 32'd1);
        run_until_halt(30, 1'b0, cyc, ex);
        chk("straight_cycles", 32'(cyc), 32'd8);
        chk("straight_pc", 32'(pc), 32'd3);
        chk("straight_status", 32'({running, halted, exec_en, imem_req, wrap_err}), 32'b01000);
        chk("straight_sb_empty", 32'(sb_q.size()), 32'd0);

        // Restart from HALTED plus memory wait on address 1, with start and halt noise
        mem[2] = 8'hF0;
        wait_addr  = 1;
        wait_left  = 3;
        req1_cnt   = 0;
        halt_noise = 1'b1;
        push(4'h1, 4'hA, 4'd0);
        push(4'h3, 4'h5, 4'd1);
        push(4'hF, 4'h0, 4'd2);
        do_start();
        chk("restart_pc", 32'(pc), 32'd0);
        chk("restart_req", 32'({imem_req, running, halted}), 32'b110);
        run_until_halt(30, 1'b1, cyc, ex);
        halt_noise = 1'b0;
        chk("wait_cycles", 32'(cyc), 32'd9);
        chk("wait_req_addr1", 32'(req1_cnt), 32'd4);
        chk("wait_pc", 32'(pc), 32'd2);
        chk("wait_sb_empty", 32'(sb_q.size()), 32'd0);

        // Stall for 2 cycles on a halting instruction
        mem[0]     = 8'hF0;
        stall_left = 2;
        push(4'hF, 4'h0, 4'd0);
        do_start();
        run_until_halt(20, 1'b0, cyc, ex);
        chk("stall_exec_cycles", 32'(ex), 32'd3);
        chk("stall_cycles", 32'(cyc), 32'd4);
        chk("stall_pc", 32'(pc), 32'd0);
        chk("stall_halted", 32'(halted), 32'd1);

        // Asynchronous reset while fetching address 2
        load_straight();
        wait_addr = 2;
        wait_left = 5;
        push(4'h1, 4'hA, 4'd0);
        push(4'h3, 4'h5, 4'd1);
        do_start();
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 4'd2) break;
            @(posedge clk);
            #1;
        end
        chk("midfetch_reached", 32'({imem_req, imem_addr}), 32'h12);
        #2;
        reset = 1'b1;
        #1;
        chk("async_req_drop", 32'({imem_req, exec_en, running}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        wait_left = 0;
        wait_addr = -1;
        @(posedge clk);
        #1;
        chk("post_rst_state", 32'({running, halted, imem_req}), 32'd0);
        chk("post_rst_opcode", 32'(opcode), 32'd0);
        chk("post_rst_pc", 32'(pc), 32'd0);
        chk("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);

        // Sixteen non-halting instructions run off the end
        foreach (mem[i]) mem[i] = 8'h30;
        for (int i = 0; i < 16; i++) push(4'h3, 4'h0, 4'(i));
`ifdef INSTR_SEQ_WRAP_HALT_EN
        do_start();
        run_until_halt(40, 1'b0, cyc, ex);
        chk("wrap_cycles", 32'(cyc), 32'd32);
        chk("wrap_pc", 32'(pc), 32'd15);
        chk("wrap_err_set", 32'({halted, wrap_err}), 32'b11);
        chk("wrap_sb_empty", 32'(sb_q.size()), 32'd0);
        do_start();
        chk("wrap_err_clear", 32'({wrap_err, pc}), 32'd0);
        reset = 1'b1;
        #1;
        chk("wrap_rst_req", 32'(imem_req), 32'd0);
`else
        push(4'h3, 4'h0, 4'd0);
        push(4'h3, 4'h0, 4'd1);
        do_start();
        repeat (36) @(posedge clk);
        #1;
        chk("nowrap_pc", 32'(pc), 32'd2);
        chk("nowrap_status", 32'({imem_req, running, halted, wrap_err}), 32'b1100);
        chk("nowrap_sb_empty", 32'(sb_q.size()), 32'd0);
        reset = 1'b1;
        #1;
        chk("nowrap_rst_req", 32'(imem_req), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Fetch/sequence engine that produces the opcode stream the control unit decodes.
- Walks a program counter over instruction memory and latches each 8-bit instruction into an instruction register.
- Presents the opcode and operand to the decoder, then advances or stops on the decoder's halt indication.
- Sits between instruction memory and the control unit in the 4-bit RISC core.

## Interface
Parameters:
- ADDR_W, 4, program counter / instruction memory address width
- INSTR_W, 8, instruction width; opcode = instr[INSTR_W-1 -: OPC_W], operand = remaining low bits
- OPC_W, 4, opcode width (matches control unit opcode input)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  begin execution at address 0; honoured only in IDLE or HALTED
- imem_req  output  1  instruction read request
- imem_addr  output  ADDR_W  read address (equals pc)
- imem_valid  input  1  read data valid; sampled only while imem_req=1
- imem_rdata  input  INSTR_W  instruction word
- opcode  output  OPC_W  registered opcode to control unit
- operand  output  INSTR_W-OPC_W  registered operand field
- exec_en  output  1  high while the instruction is being executed
- stall  input  1  datapath busy; holds EXECUTE
- halt  input  1  from control unit; sampled on EXECUTE completion
- pc  output  ADDR_W  current program counter
- running  output  1  high in FETCH or EXECUTE
- halted  output  1  high in HALTED
- wrap_err  output  1  program ran off the end (see Configuration)

## Operation
- States: IDLE, FETCH, EXECUTE, HALTED. Reset state IDLE.
- IDLE/HALTED: start=1 -> pc<=0, clear wrap_err, go FETCH. All other inputs ignored.
- FETCH: imem_req=1, imem_addr=pc. Stays until imem_valid=1. On that edge, latch imem_rdata into the instruction register, then go EXECUTE.
- EXECUTE: exec_en=1 every cycle. stall=1 -> remain, opcode/operand/pc frozen. Completion is the first cycle with stall=0:
  - halt=1 -> HALTED, pc unchanged (points at halting instruction).
  - else pc<=pc+1 (modulo 2^ADDR_W), go FETCH.
- start while running: ignored. imem_valid outside FETCH: ignored. halt outside EXECUTE completion: ignored.
- Reset values: imem_req=0, imem_addr=0, opcode=0, operand=0, exec_en=0, pc=0, running=0, halted=0, wrap_err=0.
- Reset mid-operation: the asynchronous reset drops imem_req and exec_en without waiting for a clock edge. Any in-flight memory response is discarded.

## Timing
- All outputs are registered or decoded from state only; there are no combinational input->output paths.
- Zero-wait memory (imem_valid high in the first FETCH cycle): 2 cycles per instruction (1 FETCH + 1 EXECUTE).
- Each memory wait cycle adds 1 cycle. Each stall cycle adds 1 cycle.
- opcode changes only on the FETCH->EXECUTE edge. It is stable for the whole of EXECUTE and holds its last value in FETCH, HALTED and IDLE.
- start->first imem_req: 1 cycle (state registers on the start edge).
- Simultaneous stall=1 and halt=1: stall wins; halt is re-sampled at completion.

## Configuration
- INSTR_SEQ_WRAP_HALT_EN defined:
  - Completing a non-halting instruction at pc=2^ADDR_W-1 goes to HALTED instead of wrapping.
  - It sets wrap_err=1 and leaves pc=2^ADDR_W-1.
  - wrap_err clears on start or reset.
- Not defined: pc wraps to 0 and execution continues; wrap_err is constant 0.

## Test plan
- Straight-line run:
  - Stimulus: memory {0x1A, 0x35, 0x4F, 0xF0}, zero wait, start pulse.
  - Response: opcodes 1,3,4,F appear on consecutive EXECUTE cycles 2 cycles apart; operands A,5,F,0.
  - After 0xF0 completes: halted=1, pc=3, running=0.
- Memory wait: imem_valid delayed 3 cycles on address 1 -> imem_req held 4 cycles at imem_addr=1; opcode unchanged until capture.
- Stall then halt:
  - Stimulus: instruction 0xF0 with stall=1 for 2 cycles and halt=1 throughout.
  - Response: exec_en high 3 cycles, HALTED entered on the 3rd edge, pc not incremented.
- Restart: start in HALTED -> pc=0, imem_req=1 next cycle. start pulsed mid-run -> no effect on pc or state.
- Reset mid-FETCH: reset asserted between clock edges -> imem_req=0 immediately; after release state IDLE, opcode=0, pc=0.
- Wrap:
  - Stimulus: 16 words of 0x30 (no halt).
  - With INSTR_SEQ_WRAP_HALT_EN: halted=1, wrap_err=1, pc=15.
  - Without: pc returns to 0 and fetch continues; wrap_err=0.
